// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO between the memory stage and data
// memory. Stores drain in program order over a valid/ready handshake, and
// loads are forwarded from the youngest buffered store with a matching address.
module store_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  input  logic [ADDR_W-1:0]            st_addr,
  input  logic [DATA_W-1:0]            st_data,
  output logic                         st_ready,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         ld_hit,
  output logic [DATA_W-1:0]            ld_data,
  output logic                         result_active,
  output logic [ADDR_W-1:0]            result_addr,
  output logic [DATA_W-1:0]            result,
  input  logic                         mem_ready,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic              w_st_ready;
  logic              w_empty;
  logic [PTR_W-1:0]  w_fwd_idx;

  assign w_empty    = (r_count == '0);
  assign w_st_ready = (r_count != CNT_W'(DEPTH));
  assign w_push     = st_valid && w_st_ready;
  assign w_pop      = !w_empty && mem_ready;

  assign st_ready      = w_st_ready;
  assign empty         = w_empty;
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign result_active = !w_empty;
  assign result_addr   = r_addr[r_rd_ptr];
  assign result        = r_data[r_rd_ptr];

  // Entry storage: written on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= st_addr;
      r_data[r_wr_ptr] <= st_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      if (st_valid && !w_st_ready) r_overflow <= 1'b1;
    end
  end

  // Forwarding lookup: walk entries oldest-to-youngest starting at rd_ptr, so
  // the last match found is the youngest regardless of where the pointers wrap.
  always_comb begin
    ld_hit    = 1'b0;
    ld_data   = '0;
    w_fwd_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_fwd_idx = r_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_addr[w_fwd_idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = r_data[w_fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the buffer.
module tb_store_write_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_ready;
  logic [31:0] ld_addr = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        result_active;
  logic [31:0] result_addr;
  logic [31:0] result;
  logic        mem_ready = 1'b0;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t m_q[$];
  bit   m_ovf = 1'b0;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .result_active(result_active), .result_addr(result_addr), .result(result),
    .mem_ready(mem_ready), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO queue advanced once per rising edge.
  task automatic model_edge();
    bit can_push;
    bit do_pop;
    if (!reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      return;
    end
    can_push = (m_q.size() < DEPTH);
    do_pop   = (m_q.size() > 0) && mem_ready;
    if (st_valid && !can_push) m_ovf = 1'b1;
    if (do_pop) void'(m_q.pop_front());
    if (st_valid && can_push) m_q.push_back('{a: st_addr, d: st_data});
  endtask

  function automatic void model_ld(input logic [31:0] a, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (m_q[i]) if (m_q[i].a == a) begin
      hit = 1'b1;
      d   = m_q[i].d;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; st_valid = 1'b0; mem_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %0b exp 1", st_ready); end
    checks++; if (result_active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b exp 0", result_active); end
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL reset_ld_hit got %0b exp 0", ld_hit); end
    checks++; if (ld_data !== 32'd0) begin errors++; $display("FAIL reset_ld_data got %0h exp 0", ld_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    int act;
    do_reset();
    st_valid = 1'b1; st_addr = 32'd84; st_data = 32'd71; mem_ready = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d exp 0", count); end
    tick();
    st_valid = 1'b0;
    #1;
    checks++; if (result_active !== 1'b1) begin errors++; $display("FAIL single_active got %0b exp 1", result_active); end
    checks++; if (result_addr !== 32'd84) begin errors++; $display("FAIL single_addr got %0d exp 84", result_addr); end
    checks++; if (result !== 32'd71) begin errors++; $display("FAIL single_data got %0d exp 71", result); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", count); end
    act = 1;
    repeat (4) begin
      tick();
      if (result_active) act++;
    end
    checks++; if (act !== 1) begin errors++; $display("FAIL single_active_cycles got %0d exp 1", act); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_end got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %0b exp 1", empty); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'(4*i), 32'(i+1));
    #1;
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL fill_st_ready got %0b exp 0", st_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_pre got %0b exp 0", overflow); end
    push(32'd16, 32'd5);
    #1;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %0b exp 1", overflow); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count_after got %0d exp 4", count); end
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (result_active !== 1'b1 || result !== 32'(i+1) || result_addr !== 32'(4*i)) begin
        errors++; $display("FAIL fill_drain%0d got act=%0b addr=%0d data=%0d exp act=1 addr=%0d data=%0d",
                           i, result_active, result_addr, result, 4*i, i+1);
      end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty got %0b exp 1", empty); end
  endtask

  task automatic test_forward();
    do_reset();
    push(32'd84, 32'd10);
    push(32'd84, 32'd71);
    ld_addr = 32'd84; #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'd71) begin
      errors++; $display("FAIL fwd_youngest got hit=%0b data=%0d exp hit=1 data=71", ld_hit, ld_data); end
    ld_addr = 32'd88; #1;
    checks++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin
      errors++; $display("FAIL fwd_miss got hit=%0b data=%0d exp hit=0 data=0", ld_hit, ld_data); end
    st_valid = 1'b1; st_addr = 32'd88; st_data = 32'd5; #1;
    checks++; if (ld_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_same_cycle_push got hit=%0b exp 0", ld_hit); end
    tick();
    st_valid = 1'b0; #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'd5) begin
      errors++; $display("FAIL fwd_after_push got hit=%0b data=%0d exp hit=1 data=5", ld_hit, ld_data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(32'h100, 32'd100);
    push(32'h104, 32'd101);
    mem_ready = 1'b1;
    st_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      st_addr = 32'(32'h108 + 4*i); st_data = 32'(102 + i);
      #1;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d got %0d exp 2", i, count); end
      checks++; if (result !== 32'(100 + i) || result_addr !== 32'(32'h100 + 4*i)) begin
        errors++; $display("FAIL b2b_order%0d got addr=%0h data=%0d exp addr=%0h data=%0d",
                           i, result_addr, result, 32'h100 + 4*i, 100 + i); end
      tick();
    end
    st_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      #1;
      checks++; if (result_active !== 1'b1 || result !== 32'(100 + i)) begin
        errors++; $display("FAIL b2b_tail%0d got act=%0b data=%0d exp act=1 data=%0d", i, result_active, result, 100 + i); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %0b exp 1", empty); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'(32'h40 + 4*i), 32'(32'h20 + i));
    mem_ready = 1'b1; st_valid = 1'b1; st_addr = 32'h50; st_data = 32'h99;
    #1;
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL fullpop_st_ready got %0b exp 0", st_ready); end
    tick();
    st_valid = 1'b0; mem_ready = 1'b0; ld_addr = 32'h50; #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got %0d exp 3", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fullpop_ovf got %0b exp 1", overflow); end
    checks++; if (result !== 32'h21) begin errors++; $display("FAIL fullpop_head got %0h exp 21", result); end
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fullpop_dropped_fwd got %0b exp 0", ld_hit); end
  endtask

  task automatic test_reset_mid();
    int writes;
    do_reset();
    for (int i = 0; i < 4; i++) push(32'(32'h80 + 4*i), 32'(i + 7));
    mem_ready = 1'b1;
    push(32'h90, 32'd99);
    mem_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd3 || overflow !== 1'b1) begin
      errors++; $display("FAIL midrst_setup got count=%0d ovf=%0b exp count=3 ovf=1", count, overflow); end
    reset = 1'b0;
    #1;
    checks++; if (result_active !== 1'b0) begin errors++; $display("FAIL midrst_active got %0b exp 0", result_active); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %0b exp 0", overflow); end
    #4;
    reset = 1'b1;
    m_q.delete();
    m_ovf = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    writes = 0;
    repeat (4) begin
      if (result_active) writes++;
      tick();
    end
    checks++; if (writes !== 0) begin errors++; $display("FAIL midrst_writes got %0d exp 0", writes); end
  endtask

  task automatic test_random();
    bit          e_hit;
    logic [31:0] e_ld;
    int          sz;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      st_valid  = ($urandom_range(0, 3) != 0);
      mem_ready = (c % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      st_addr   = 32'({$urandom_range(0, 7), 2'b00});
      st_data   = $urandom;
      ld_addr   = 32'({$urandom_range(0, 7), 2'b00});
      #1;
      sz = m_q.size();
      model_ld(ld_addr, e_hit, e_ld);
      checks++; if (count !== 3'(sz) || st_ready !== (sz < DEPTH) || empty !== (sz == 0) ||
                    result_active !== (sz > 0) || overflow !== m_ovf) begin
        errors++; $display("FAIL rand_state c=%0d got cnt=%0d rdy=%0b emp=%0b act=%0b ovf=%0b exp cnt=%0d ovf=%0b",
                           c, count, st_ready, empty, result_active, overflow, sz, m_ovf); end
      if (sz > 0) begin
        checks++; if (result_addr !== m_q[0].a || result !== m_q[0].d) begin
          errors++; $display("FAIL rand_head c=%0d got addr=%0h data=%0h exp addr=%0h data=%0h",
                             c, result_addr, result, m_q[0].a, m_q[0].d); end
      end
      checks++; if (ld_hit !== e_hit || ld_data !== e_ld) begin
        errors++; $display("FAIL rand_fwd c=%0d got hit=%0b data=%0h exp hit=%0b data=%0h",
                           c, ld_hit, ld_data, e_hit, e_ld); end
      tick();
    end
    st_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
